// File: rtl/peripheral_io_seq.sv
// peripheral_io_seq: push-button operand loader and result viewer.
//   Operands are entered one BYTE_W chunk per rising edge of the enter button.
//   Once every operand is loaded, inputdata_ready is raised until the datapath
//   returns a result. The result can then be browsed 16 bits at a time on four
//   seven-segment digits.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   enter             raw push-button level (edge detected internally)
//   inputdata         chunk stored on each accepted press
//   loaddata          1 = presses load data / restart, 0 = presses browse
//   result_valid      one-cycle strobe qualifying dataR
//   dataR             result from the datapath
//   operands          operand k at bits [k*DATA_W +: DATA_W]
//   inputdata_ready   high while operands are complete and a result is pending
//   disp3..disp0      registered active-low seven-segment codes (gfedcba)
module peripheral_io_seq #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BYTE_W  = 8,
  parameter int unsigned NUM_OPS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enter,
  input  logic [BYTE_W-1:0]          inputdata,
  input  logic                       loaddata,
  input  logic                       result_valid,
  input  logic [DATA_W-1:0]          dataR,
  output logic [NUM_OPS*DATA_W-1:0]  operands,
  output logic                       inputdata_ready,
  output logic [6:0]                 disp3,
  output logic [6:0]                 disp2,
  output logic [6:0]                 disp1,
  output logic [6:0]                 disp0
);

  localparam int unsigned Chunks = DATA_W / BYTE_W;
  localparam int unsigned Wins   = DATA_W / 16;
  // Single-entry ranges still get a 1-bit counter held at zero.
  localparam int unsigned OpW    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int unsigned ByteW  = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam int unsigned WinW   = (Wins > 1) ? $clog2(Wins) : 1;

  localparam logic [OpW-1:0]   OpLast   = OpW'(NUM_OPS - 1);
  localparam logic [ByteW-1:0] ByteLast = ByteW'(Chunks - 1);
  localparam logic [WinW-1:0]  WinLast  = WinW'(Wins - 1);
  localparam logic [6:0]       SegDash  = 7'b0111111;
  localparam logic [6:0]       SegZero  = 7'b1000000;

  typedef enum logic [1:0] {StLoad, StReady, StShow} state_e;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  state_e                      state_q, state_d;
  logic [OpW-1:0]              op_idx_q, op_idx_d;
  logic [ByteW-1:0]            byte_idx_q, byte_idx_d;
  logic [WinW-1:0]             win_idx_q, win_idx_d;
  logic                        enter_q;
  logic [NUM_OPS*DATA_W-1:0]   operands_q, operands_d;
  logic [DATA_W-1:0]           result_q, result_d;
  logic                        ready_q, ready_d;
  logic [BYTE_W-1:0]           last_q, last_d;
  logic [6:0]                  disp3_q, disp2_q, disp1_q, disp0_q;
  logic [6:0]                  disp3_d, disp2_d, disp1_d, disp0_d;

  logic                        enter_pulse;
  logic                        wr_en;
  logic [OpW-1:0]              wr_op;
  logic [ByteW-1:0]            wr_byte;
  logic [15:0]                 win_data;
  logic [7:0]                  chunk8;

  assign enter_pulse = enter & ~enter_q;

  // Sequencer: decides whether this cycle writes a chunk, and where.
  always_comb begin
    state_d    = state_q;
    op_idx_d   = op_idx_q;
    byte_idx_d = byte_idx_q;
    win_idx_d  = win_idx_q;
    operands_d = operands_q;
    result_d   = result_q;
    ready_d    = ready_q;
    last_d     = last_q;
    wr_en      = 1'b0;
    wr_op      = op_idx_q;
    wr_byte    = byte_idx_q;

    unique case (state_q)
      StLoad: begin
        if (enter_pulse && loaddata) wr_en = 1'b1;
      end
      StReady: begin
        if (result_valid) begin
          result_d  = dataR;
          ready_d   = 1'b0;
          win_idx_d = '0;
          state_d   = StShow;
        end
      end
      StShow: begin
        if (enter_pulse) begin
          if (loaddata) begin
            // Restart: this same press becomes chunk 0 of operand 0.
            wr_en   = 1'b1;
            wr_op   = '0;
            wr_byte = '0;
            state_d = StLoad;
          end else begin
            win_idx_d = (win_idx_q == WinLast) ? '0 : win_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StLoad;
    endcase

    if (wr_en) begin
      for (int k = 0; k < int'(NUM_OPS); k++) begin
        for (int b = 0; b < int'(Chunks); b++) begin
          if (wr_op == OpW'(k) && wr_byte == ByteW'(b)) begin
            operands_d[k*DATA_W + b*BYTE_W +: BYTE_W] = inputdata;
          end
        end
      end
      last_d = inputdata;
      if (wr_byte == ByteLast) begin
        byte_idx_d = '0;
        if (wr_op == OpLast) begin
          op_idx_d = '0;
          state_d  = StReady;
          ready_d  = 1'b1;
        end else begin
          op_idx_d = wr_op + 1'b1;
        end
      end else begin
        byte_idx_d = wr_byte + 1'b1;
        op_idx_d   = wr_op;
      end
    end
  end

  // Display decode from the current registered state; registering it adds
  // one cycle of latency relative to the state change.
  always_comb begin
    win_data = result_q[15:0];
    for (int w = 0; w < int'(Wins); w++) begin
      if (win_idx_q == WinW'(w)) win_data = result_q[w*16 +: 16];
    end
    chunk8 = 8'(last_q);

    disp3_d = SegZero;
    disp2_d = SegZero;
    disp1_d = SegZero;
    disp0_d = SegZero;
    unique case (state_q)
      StLoad: begin
        disp3_d = hex7(4'(op_idx_q));
        disp2_d = hex7(4'(byte_idx_q));
        disp1_d = hex7(chunk8[7:4]);
        disp0_d = hex7(chunk8[3:0]);
      end
      StReady: begin
        disp3_d = SegDash;
        disp2_d = SegDash;
        disp1_d = SegDash;
        disp0_d = SegDash;
      end
      StShow: begin
        disp3_d = hex7(win_data[15:12]);
        disp2_d = hex7(win_data[11:8]);
        disp1_d = hex7(win_data[7:4]);
        disp0_d = hex7(win_data[3:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StLoad;
      op_idx_q   <= '0;
      byte_idx_q <= '0;
      win_idx_q  <= '0;
      enter_q    <= 1'b0;
      operands_q <= '0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      last_q     <= '0;
      disp3_q    <= SegZero;
      disp2_q    <= SegZero;
      disp1_q    <= SegZero;
      disp0_q    <= SegZero;
    end else begin
      state_q    <= state_d;
      op_idx_q   <= op_idx_d;
      byte_idx_q <= byte_idx_d;
      win_idx_q  <= win_idx_d;
      enter_q    <= enter;
      operands_q <= operands_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      last_q     <= last_d;
      disp3_q    <= disp3_d;
      disp2_q    <= disp2_d;
      disp1_q    <= disp1_d;
      disp0_q    <= disp0_d;
    end
  end

  assign operands        = operands_q;
  assign inputdata_ready = ready_q;
  assign disp3           = disp3_q;
  assign disp2           = disp2_q;
  assign disp1           = disp1_q;
  assign disp0           = disp0_q;

endmodule
